// File: rtl/fx_bus_master.sv
// Byte-stream bus master: parses host frames (CMD, A2, A1, A0, LEN, data)
// into single-cycle write/read strobes on the fx register bus.
module fx_bus_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [21:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [21:0] fx_raddr,
  input  logic [7:0]  fx_q,
  output logic        busy,
  output logic        err_cmd
);

  // Handshakes: a byte moves on rx (or tx) in a cycle where valid & ready are
  // both high at the rising edge; the sender holds data stable until then.
  typedef enum logic [3:0] {
    IDLE, ADR2, ADR1, ADR0, LENG, WDAT, RISS, RWAIT, RSEND
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t      state, state_nxt;
  logic [21:0] addr;
  logic [21:0] addr_inc;
  logic [8:0]  cnt;
  logic [2:0]  lat_cnt;
  logic        is_rd;
  logic        rx_acc;
  logic        tx_acc;
  logic        cmd_ok;

  assign rx_rdy   = rst_n & (state inside {IDLE, ADR2, ADR1, ADR0, LENG, WDAT});
  assign tx_vld   = (state == RSEND);
  assign busy     = (state != IDLE);
  assign fx_rd    = (state == RISS);
  assign rx_acc   = rx_vld & rx_rdy;
  assign tx_acc   = tx_vld & tx_rdy;
  assign cmd_ok   = (rx_data == 8'h01) || (rx_data == 8'h02);
  // Only the register field wraps; the device id is fixed for the whole frame.
  assign addr_inc = {addr[21:16], addr[15:0] + 16'd1};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_acc && cmd_ok) state_nxt = ADR2;
      ADR2:  if (rx_acc) state_nxt = ADR1;
      ADR1:  if (rx_acc) state_nxt = ADR0;
      ADR0:  if (rx_acc) state_nxt = LENG;
      LENG:  if (rx_acc) state_nxt = is_rd ? RISS : WDAT;
      WDAT:  if (rx_acc && cnt == 9'd1) state_nxt = IDLE;
      RISS:  state_nxt = RWAIT;
      RWAIT: if (lat_cnt == LAT) state_nxt = RSEND;
      RSEND: if (tx_acc) state_nxt = (cnt == 9'd1) ? IDLE : RISS;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      cnt      <= '0;
      lat_cnt  <= '0;
      is_rd    <= 1'b0;
      err_cmd  <= 1'b0;
      fx_wr    <= 1'b0;
      fx_data  <= '0;
      fx_waddr <= '0;
      fx_raddr <= '0;
      tx_data  <= '0;
    end else begin
      fx_wr   <= 1'b0;
      fx_data <= '0;
      err_cmd <= 1'b0;
      case (state)
        IDLE: if (rx_acc) begin
          if (cmd_ok) is_rd   <= (rx_data == 8'h02);
          else        err_cmd <= 1'b1;
        end
        ADR2: if (rx_acc) addr[21:16] <= rx_data[5:0];
        ADR1: if (rx_acc) addr[15:8]  <= rx_data;
        ADR0: if (rx_acc) addr[7:0]   <= rx_data;
        LENG: if (rx_acc) begin
          cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          if (is_rd) fx_raddr <= addr;
        end
        WDAT: if (rx_acc) begin
          fx_wr    <= 1'b1;
          fx_data  <= rx_data;
          fx_waddr <= addr;
          addr     <= addr_inc;
          cnt      <= cnt - 9'd1;
        end
        RISS:  lat_cnt <= 3'd1;
        RWAIT: begin
          if (lat_cnt == LAT) tx_data <= fx_q;
          else                lat_cnt <= lat_cnt + 3'd1;
        end
        RSEND: if (tx_acc) begin
          addr <= addr_inc;
          cnt  <= cnt - 9'd1;
          // Read address is preloaded for the next strobe, held after the last.
          if (cnt != 9'd1) fx_raddr <= addr_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
